inv_sbox_seq: RTL and testbench



---
 rtl/aes_mod_pkg.sv | 23 ++
 rtl/inv_sbox_mask_cache.sv | 53 +++++
 rtl/inv_sbox_seq.sv | 154 +++++++++++++++
 tb/tb_inv_sbox_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mod_pkg
//  Description : Shared types and constants for the modified AES-256
//                decryption datapath: block/round/seed widths, the AES-256
//                round count and the inverse-substitution stage FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_mod_pkg;

    localparam int BLOCK_W       = 128;
    localparam int ROUND_W       = 32;
    localparam int SEED_W        = 256;
    localparam int AES256_ROUNDS = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2
    } inv_sbox_state_e;

endpackage
`default_nettype wire

// File: rtl/inv_sbox_mask_cache.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sbox_mask_cache
//  Description : One-entry mask cache: round tag, 128-bit mask and a valid
//                bit. Lookup is combinational; fill and flush are registered.
//                Flush wins over a fill in the same cycle.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_flush         - invalidate the entry
//                i_fill          - write tag/mask and set valid
//                i_fill_tag      - round tag to store
//                i_fill_mask     - mask to store
//                i_lookup_tag    - round to look up
//                o_hit           - entry valid and tag matches
//                o_mask          - stored mask
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox_mask_cache
    import aes_mod_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_fill,
    input  logic [ROUND_W-1:0] i_fill_tag,
    input  logic [BLOCK_W-1:0] i_fill_mask,
    input  logic [ROUND_W-1:0] i_lookup_tag,
    output logic               o_hit,
    output logic [BLOCK_W-1:0] o_mask
);

    logic               r_valid;
    logic [ROUND_W-1:0] r_tag;
    logic [BLOCK_W-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_mask  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_mask  <= i_fill_mask;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/inv_sbox_seq.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sbox_seq
//  Description : Sequential inverse substitution stage. Accepts one 128-bit
//                state block with its round number, obtains the per-round
//                mask from the keystream generator (req/ack) and returns
//                state ^ mask. Out-of-range rounds bypass the generator and
//                return the block unchanged with out_err set.
//  Build macro : INV_SBOX_MASK_CACHE_EN - adds a one-entry round/mask cache
//                so repeated rounds skip the keystream fetch.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                in_valid/in_ready         - upstream handshake
//                in_data, in_round         - block and its round number
//                seed_change               - keystream seed changed (flush)
//                prng_req/prng_ack         - keystream handshake
//                prng_round, prng_random   - requested round, returned mask
//                out_valid/out_ready       - downstream handshake
//                out_data, out_err         - result and range-error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox_seq
    import aes_mod_pkg::*;
#(
    parameter int NUM_ROUNDS = AES256_ROUNDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [ROUND_W-1:0] in_round,
    input  logic               seed_change,
    output logic               prng_req,
    output logic [ROUND_W-1:0] prng_round,
    input  logic               prng_ack,
    input  logic [BLOCK_W-1:0] prng_random,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_err
);

    localparam logic [1:0] c_st_idle  = ST_IDLE;
    localparam logic [1:0] c_st_fetch = ST_FETCH;
    localparam logic [1:0] c_st_out   = ST_OUT;

    logic [1:0]         r_state;
    logic [BLOCK_W-1:0] r_data;
    logic [ROUND_W-1:0] r_round;
    logic [BLOCK_W-1:0] r_out_data;
    logic               r_out_err;

    logic               w_round_bad;
    logic               w_hit;
    logic [BLOCK_W-1:0] w_cache_mask;

    // Unsigned compare: any value above NUM_ROUNDS (including the top of
    // the 32-bit range) is illegal.
    assign w_round_bad = (in_round == '0) || (in_round > ROUND_W'(NUM_ROUNDS));

`ifdef INV_SBOX_MASK_CACHE_EN
    logic r_fill_blocked;
    logic w_cache_hit;
    logic w_fill;

    // A seed change at any point during a fetch makes the acknowledged mask
    // stale for future blocks, so it must not be cached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_blocked <= 1'b0;
        end else if (r_state != c_st_fetch) begin
            r_fill_blocked <= 1'b0;
        end else if (seed_change) begin
            r_fill_blocked <= 1'b1;
        end
    end

    assign w_fill = (r_state == c_st_fetch) && prng_ack && !seed_change && !r_fill_blocked;
    // A lookup coinciding with a seed change sees a flushed cache.
    assign w_hit  = w_cache_hit && !seed_change;

    inv_sbox_mask_cache u_mask_cache (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (seed_change),
        .i_fill       (w_fill),
        .i_fill_tag   (r_round),
        .i_fill_mask  (prng_random),
        .i_lookup_tag (in_round),
        .o_hit        (w_cache_hit),
        .o_mask       (w_cache_mask)
    );
`else
    // Without a cache every legal block is fetched; seed changes are moot.
    logic w_unused_seed_change;
    assign w_unused_seed_change = seed_change;
    assign w_hit                = 1'b0;
    assign w_cache_mask         = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_data     <= '0;
            r_round    <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_round <= in_round;
                        if (w_round_bad) begin
                            r_out_data <= in_data;
                            r_out_err  <= 1'b1;
                            r_state    <= c_st_out;
                        end else if (w_hit) begin
                            r_out_data <= in_data ^ w_cache_mask;
                            r_out_err  <= 1'b0;
                            r_state    <= c_st_out;
                        end else begin
                            r_state    <= c_st_fetch;
                        end
                    end
                end
                c_st_fetch: begin
                    if (prng_ack) begin
                        r_out_data <= r_data ^ prng_random;
                        r_out_err  <= 1'b0;
                        r_state    <= c_st_out;
                    end
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == c_st_idle);
    assign prng_req   = (r_state == c_st_fetch);
    assign prng_round = r_round;
    assign out_valid  = (r_state == c_st_out);
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_inv_sbox_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_sbox_seq
//  Description : Scoreboard bench for inv_sbox_seq. Stimulus pushes the
//                hand-computed result into a queue; a monitor pops and
//                compares on every accepted output. Works in both builds
//                (INV_SBOX_MASK_CACHE_EN defined or not).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sbox_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [31:0]  in_round;
    logic         seed_change;
    logic         prng_req;
    logic [31:0]  prng_round;
    logic         prng_ack;
    logic [127:0] prng_random;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_err;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] c_m5  = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;
    localparam logic [127:0] c_m5b = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    always #5 clk = ~clk;

    inv_sbox_seq #(.NUM_ROUNDS(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_round    (in_round),
        .seed_change (seed_change),
        .prng_req    (prng_req),
        .prng_round  (prng_round),
        .prng_ack    (prng_ack),
        .prng_random (prng_random),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err)
    );

    task automatic check1(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h err %b expected no output", out_data, out_err);
            end else begin
                m_e = exp_q.pop_front();
                check1("out_data", out_data, m_e.data);
                check1("out_err", {127'd0, out_err}, {127'd0, m_e.err});
            end
        end
    end

    // One transaction. miss: expect a keystream fetch acked in cycle
    // t+ack_delay; hold: extra cycles out_ready is kept low.
    task automatic send(input logic [127:0] data, input logic [31:0] round,
                        input logic [127:0] mask, input logic [127:0] exp_data,
                        input logic exp_err, input bit miss, input int ack_delay,
                        input int hold);
        exp_t         e;
        logic [127:0] held;
        check1("in_ready_idle", {127'd0, in_ready}, 128'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = data;
        in_round  = round;
        e.data    = exp_data;
        e.err     = exp_err;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        in_round = '0;
        if (miss) begin
            for (int i = 1; i < ack_delay; i++) begin
                check1("prng_req_held", {127'd0, prng_req}, 128'd1);
                check1("prng_round_held", {96'd0, prng_round}, {96'd0, round});
                check1("out_valid_early", {127'd0, out_valid}, 128'd0);
                check1("in_ready_busy", {127'd0, in_ready}, 128'd0);
                tick();
            end
            check1("prng_req_ack", {127'd0, prng_req}, 128'd1);
            check1("prng_round_ack", {96'd0, prng_round}, {96'd0, round});
            prng_ack    = 1'b1;
            prng_random = mask;
            tick();
            prng_ack    = 1'b0;
            prng_random = '0;
        end else begin
            check1("no_prng_req", {127'd0, prng_req}, 128'd0);
        end
        check1("out_valid_latency", {127'd0, out_valid}, 128'd1);
        check1("prng_req_in_out", {127'd0, prng_req}, 128'd0);
        if (hold > 0) begin
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                tick();
                check1("bp_out_valid", {127'd0, out_valid}, 128'd1);
                check1("bp_out_data", out_data, held);
                check1("bp_in_ready", {127'd0, in_ready}, 128'd0);
            end
            out_ready = 1'b1;
        end
        tick();
        check1("out_valid_after", {127'd0, out_valid}, 128'd0);
        check1("in_ready_after", {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_round    = '0;
        seed_change = 1'b0;
        prng_ack    = 1'b0;
        prng_random = '0;
        out_ready   = 1'b1;
        tick();
        tick();
        check1("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check1("rst_prng_req", {127'd0, prng_req}, 128'd0);
        check1("rst_prng_round", {96'd0, prng_round}, 128'd0);
        check1("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check1("rst_out_data", out_data, 128'd0);
        check1("rst_out_err", {127'd0, out_err}, 128'd0);
        rst = 1'b0;
        tick();

        // Miss, ack delay 3: out_valid in cycle t+4.
        send(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 32'd5, c_m5,
             128'hFFEE_DDCC_4455_6677_7766_5544_CCDD_EEFF, 1'b0, 1'b1, 3, 0);

        // Same round again: served from the cache when present.
`ifdef INV_SBOX_MASK_CACHE_EN
        send(128'd0, 32'd5, 128'd0, c_m5, 1'b0, 1'b0, 0, 0);
`else
        send(128'd0, 32'd5, c_m5, c_m5, 1'b0, 1'b1, 1, 0);
`endif

        // Seed change forces a fresh fetch; new mask then cached.
        seed_change = 1'b1;
        tick();
        seed_change = 1'b0;
        send(128'd0, 32'd5, c_m5b, c_m5b, 1'b0, 1'b1, 2, 0);
`ifdef INV_SBOX_MASK_CACHE_EN
        send({128{1'b1}}, 32'd5, 128'd0,
             128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, 1'b0, 1'b0, 0, 0);
`else
        send({128{1'b1}}, 32'd5, c_m5b,
             128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, 1'b0, 1'b1, 1, 0);
`endif

        // Illegal rounds: passthrough with error, no fetch.
        send({32{4'hA}}, 32'd0, 128'd0, {32{4'hA}}, 1'b1, 1'b0, 0, 0);
        send({32{4'h5}}, 32'd15, 128'd0, {32{4'h5}}, 1'b1, 1'b0, 0, 0);
        send(128'h1234, 32'hFFFF_FFFF, 128'd0, 128'h1234, 1'b1, 1'b0, 0, 0);

        // Top legal round, minimum miss latency.
        send(128'd0, 32'd14, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
             128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0, 1'b1, 1, 0);

        // Backpressure for 5 cycles.
        send(128'h1, 32'd3, 128'h3, 128'h2, 1'b0, 1'b1, 2, 5);

        // Reset while fetching: block dropped, late ack ignored.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 128'hCAFE;
        in_round  = 32'd7;
        tick();
        in_valid  = 1'b0;
        check1("fetch_before_rst", {127'd0, prng_req}, 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("rst_fetch_prng_req", {127'd0, prng_req}, 128'd0);
        check1("rst_fetch_in_ready", {127'd0, in_ready}, 128'd1);
        check1("rst_fetch_out_valid", {127'd0, out_valid}, 128'd0);
        prng_ack    = 1'b1;
        prng_random = 128'hFFFF;
        tick();
        prng_ack    = 1'b0;
        prng_random = '0;
        check1("late_ack_out_valid", {127'd0, out_valid}, 128'd0);
        check1("late_ack_prng_req", {127'd0, prng_req}, 128'd0);
        tick();
        check1("late_ack_out_valid2", {127'd0, out_valid}, 128'd0);

        // Reset also empties the cache: round 5 fetches again.
        send(128'd0, 32'd5, c_m5, c_m5, 1'b0, 1'b1, 1, 0);

        tick();
        tick();
        check1("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
